// File: rtl/noc_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_demux_pkg
// Description : Shared types for the 3-way flit demultiplexer. Provides the
//               destination encoding carried in the top bits of every flit
//               and a helper that decodes a destination field.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_demux_pkg;

    localparam int DEST_W = 2;

    typedef enum logic [DEST_W-1:0] {
        DEST_P0      = 2'b00,
        DEST_P1      = 2'b01,
        DEST_P2      = 2'b10,
        DEST_INVALID = 2'b11
    } dest_t;

    // Takes the destination field (flit[DATA_W-1 -: DEST_W]) rather than the
    // whole flit so the helper stays independent of the flit width.
    function automatic dest_t get_dest(input logic [DEST_W-1:0] dest_bits);
        return dest_t'(dest_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock in-order FIFO with a first-word-fall-through
//               head. Full/empty come straight from the registered occupancy.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               i_push/i_data - write strobe and data (ignored when full)
//               i_pop         - read strobe (ignored when empty)
//               o_data        - head entry
//               o_full/o_empty- occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    // Pointer wrap relies on natural overflow, so DEPTH must be a power of two.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == c_full_cnt);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rptr];

    // Storage is deliberately left out of reset; only the pointers matter.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/demux3_router.sv
`default_nettype none
// ============================================================================
// Module      : demux3_router
// Description : Receives a single flit stream, buffers it in order and steers
//               the head flit to one of three valid/ready output ports based
//               on the 2-bit destination in the flit's top bits. Flits with
//               destination 2'b11 are discarded as soon as they reach the head.
// Ports       : clk, reset                      - clock, sync active-high reset
//               link_dataIN/validIN/readyOUT    - upstream link
//               portN_dataOUT/validOUT/readyIN  - output ports 0..2
//               drop_count                      - saturating discard counter
// Options     : DEMUX3_DROP_CNT_EN - adds the drop_count port and counter
// Revision    : 1.0 - initial release
// ============================================================================
module demux3_router #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] link_dataIN,
    input  logic              link_validIN,
    output logic              link_readyOUT,
    output logic [DATA_W-1:0] port0_dataOUT,
    output logic [DATA_W-1:0] port1_dataOUT,
    output logic [DATA_W-1:0] port2_dataOUT,
    output logic              port0_validOUT,
    output logic              port1_validOUT,
    output logic              port2_validOUT,
    input  logic              port0_readyIN,
    input  logic              port1_readyIN,
    input  logic              port2_readyIN
`ifdef DEMUX3_DROP_CNT_EN
    ,
    output logic [7:0]        drop_count
`endif
);

    import noc_demux_pkg::*;

    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_push;
    logic              w_pop;
    logic              w_live;
    dest_t             w_dest;
    logic              w_valid0;
    logic              w_valid1;
    logic              w_valid2;
    logic              w_drop;

    // Ready depends only on registered occupancy and reset, never on a
    // same-cycle pop, so there is no combinational path from readyIN.
    assign link_readyOUT = !w_full && !reset;
    assign w_push        = link_validIN && link_readyOUT;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (link_dataIN),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_dest = get_dest(w_head[DATA_W-1 -: DEST_W]);
    // Outputs are forced quiet during the reset cycle even though the
    // occupancy register has not cleared yet.
    assign w_live = !w_empty && !reset;

    always_comb begin
        w_valid0 = 1'b0;
        w_valid1 = 1'b0;
        w_valid2 = 1'b0;
        w_drop   = 1'b0;
        if (w_live) begin
            case (w_dest)
                DEST_P0:      w_valid0 = 1'b1;
                DEST_P1:      w_valid1 = 1'b1;
                DEST_P2:      w_valid2 = 1'b1;
                default:      w_drop   = 1'b1;
            endcase
        end
    end

    // An invalid head is popped unconditionally, draining at one per cycle.
    assign w_pop = (w_valid0 && port0_readyIN) ||
                   (w_valid1 && port1_readyIN) ||
                   (w_valid2 && port2_readyIN) ||
                   w_drop;

    assign port0_dataOUT  = w_head;
    assign port1_dataOUT  = w_head;
    assign port2_dataOUT  = w_head;
    assign port0_validOUT = w_valid0;
    assign port1_validOUT = w_valid1;
    assign port2_validOUT = w_valid2;

`ifdef DEMUX3_DROP_CNT_EN
    logic [7:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule
`default_nettype wire
